// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: state encoding, PC increment, reset vector.
// Also provides word-alignment helpers used in next-PC selection.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        StFetch    = 2'd0,
        StWaitExec = 2'd1,
        StTrap     = 2'd2
    } state_e;

    localparam logic [31:0] PcIncr         = 32'd4;
    localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

    function automatic logic [31:0] align_word(logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    function automatic logic is_misaligned(logic [31:0] addr);
        return (addr & 32'h0000_0003) != 32'h0;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of fetch-side and execute-side signals of the PC sequencer.
// master: the sequencer itself; slave: memory/execute environment.
interface pc_sequencer_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        exec_done;
    logic        take_branch;
    logic [31:0] branch_target;
    logic [31:0] retire_cnt;
    logic        trap;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, pc_out, retire_cnt, trap,
        input  imem_ack, imem_rdata, stall, exec_done, take_branch, branch_target
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, pc_out, retire_cnt, trap,
        output imem_ack, imem_rdata, stall, exec_done, take_branch, branch_target
    );

endinterface

// File: rtl/pc_sequencer.sv
// Fetch/execute PC sequencer: fetches one instruction, holds it for execute, then advances PC.
// Define PC_MISALIGN_TRAP_EN to trap on misaligned branch targets instead of masking them.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DefaultResetPc
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.master bus
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] retire_q, retire_d;
    logic        imem_req;
    logic        instr_valid;
    logic [31:0] next_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StFetch;
            pc_q     <= RESET_PC;
            instr_q  <= 32'h0;
            pc_out_q <= 32'h0;
            retire_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            retire_q <= retire_d;
        end
    end

    // Low target bits are dropped here; with the trap enabled a misaligned
    // target never reaches this path.
    assign next_pc = bus.take_branch ? align_word(bus.branch_target) : pc_q + PcIncr;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        pc_out_d    = pc_out_q;
        retire_d    = retire_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;

        case (state_q)
            StFetch: begin
                imem_req = !bus.stall;
                if (imem_req && bus.imem_ack) begin
                    instr_d  = bus.imem_rdata;
                    pc_out_d = pc_q;
                    state_d  = StWaitExec;
                end
            end
            StWaitExec: begin
                instr_valid = 1'b1;
                if (bus.exec_done) begin
`ifdef PC_MISALIGN_TRAP_EN
                    if (bus.take_branch && is_misaligned(bus.branch_target)) begin
                        state_d = StTrap;
                    end else begin
                        pc_d     = next_pc;
                        retire_d = retire_q + 32'd1;
                        state_d  = StFetch;
                    end
`else
                    pc_d     = next_pc;
                    retire_d = retire_q + 32'd1;
                    state_d  = StFetch;
`endif
                end
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    assign bus.imem_req    = imem_req;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = instr_valid;
    assign bus.instr       = instr_q;
    assign bus.pc_out      = pc_out_q;
    assign bus.retire_cnt  = retire_q;

`ifdef PC_MISALIGN_TRAP_EN
    assign bus.trap = (state_q == StTrap);
`else
    assign bus.trap = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed vector table, hand-written reset/wrap sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_pc_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        stall;
        logic        ack;
        logic [31:0] rdata;
        logic        done;
        logic        br;
        logic [31:0] tgt;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc_out;
        logic [31:0] exp_retire;
        logic        exp_trap;
    } vec_t;

    vec_t vecs[20];

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    // Reference model: one instruction in flight or none, plus a trapped flag.
    logic [31:0] m_pc, m_instr, m_pc_out, m_retire;
    bit          m_busy, m_trapped;

    function automatic vec_t row(logic s, logic a, logic [31:0] rd, logic d, logic b,
                                 logic [31:0] t, logic er, logic [31:0] ea, logic ev,
                                 logic [31:0] ei, logic [31:0] ep, logic [31:0] ert,
                                 logic etr);
        vec_t v;
        v.stall = s; v.ack = a; v.rdata = rd; v.done = d; v.br = b; v.tgt = t;
        v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_instr = ei;
        v.exp_pc_out = ep; v.exp_retire = ert; v.exp_trap = etr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic s, input logic a, input logic [31:0] rd, input logic d,
                         input logic b, input logic [31:0] t);
        @(negedge clk);
        bus.stall = s; bus.imem_ack = a; bus.imem_rdata = rd;
        bus.exec_done = d; bus.take_branch = b; bus.branch_target = t;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.stall = 1'b0; bus.imem_ack = 1'b0; bus.exec_done = 1'b0; bus.take_branch = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc_out = 32'h0; m_retire = 32'h0;
        m_busy = 1'b0; m_trapped = 1'b0;
    endtask

    task automatic model_edge(input logic s, input logic a, input logic [31:0] rd,
                              input logic d, input logic b, input logic [31:0] t);
        if (m_trapped) begin
            // frozen until reset
        end else if (!m_busy) begin
            if (a && !s) begin
                m_instr = rd; m_pc_out = m_pc; m_busy = 1'b1;
            end
        end else if (d) begin
            if (TrapEn && b && (t % 4 != 0)) begin
                m_trapped = 1'b1;
            end else begin
                m_pc = b ? (t - (t % 4)) : m_pc + 32'd4;
                m_retire = m_retire + 32'd1;
                m_busy = 1'b0;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".req"}, {31'h0, bus.imem_req}, {31'h0, !m_busy && !m_trapped && !bus.stall});
        chk({tag, ".addr"}, bus.imem_addr, m_pc);
        chk({tag, ".valid"}, {31'h0, bus.instr_valid}, {31'h0, m_busy && !m_trapped});
        chk({tag, ".instr"}, bus.instr, m_instr);
        chk({tag, ".pc_out"}, bus.pc_out, m_pc_out);
        chk({tag, ".retire"}, bus.retire_cnt, m_retire);
        chk({tag, ".trap"}, {31'h0, bus.trap}, {31'h0, m_trapped});
    endtask

    initial begin
        bus.stall = 1'b0; bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
        bus.exec_done = 1'b0; bus.take_branch = 1'b0; bus.branch_target = 32'h0;

        //            s  a  rdata          d  b  tgt          req addr  v  instr        pc_out  ret trap
        vecs[0]  = row(0, 1, 32'hA000_0000, 0, 0, 32'h0,   1, 32'h0,  0, 32'h0,         32'h0,  0, 0);
        vecs[1]  = row(0, 0, 32'h0,         1, 0, 32'h0,   0, 32'h0,  1, 32'hA000_0000, 32'h0,  0, 0);
        vecs[2]  = row(0, 1, 32'hA000_0001, 0, 0, 32'h0,   1, 32'h4,  0, 32'hA000_0000, 32'h0,  1, 0);
        vecs[3]  = row(0, 0, 32'h0,         1, 0, 32'h0,   0, 32'h4,  1, 32'hA000_0001, 32'h4,  1, 0);
        vecs[4]  = row(0, 1, 32'hA000_0002, 0, 0, 32'h0,   1, 32'h8,  0, 32'hA000_0001, 32'h4,  2, 0);
        vecs[5]  = row(0, 0, 32'h0,         1, 0, 32'h0,   0, 32'h8,  1, 32'hA000_0002, 32'h8,  2, 0);
        vecs[6]  = row(1, 1, 32'hBAD0_BAD0, 0, 0, 32'h0,   0, 32'hC,  0, 32'hA000_0002, 32'h8,  3, 0);
        vecs[7]  = row(1, 1, 32'hBAD0_BAD0, 0, 0, 32'h0,   0, 32'hC,  0, 32'hA000_0002, 32'h8,  3, 0);
        vecs[8]  = row(1, 1, 32'hBAD0_BAD0, 0, 0, 32'h0,   0, 32'hC,  0, 32'hA000_0002, 32'h8,  3, 0);
        vecs[9]  = row(0, 0, 32'h0,         0, 0, 32'h0,   1, 32'hC,  0, 32'hA000_0002, 32'h8,  3, 0);
        vecs[10] = row(0, 1, 32'hA000_0003, 0, 0, 32'h0,   1, 32'hC,  0, 32'hA000_0002, 32'h8,  3, 0);
        vecs[11] = row(1, 0, 32'h0,         1, 1, 32'h10,  0, 32'hC,  1, 32'hA000_0003, 32'hC,  3, 0);
        vecs[12] = row(0, 1, 32'hA000_0004, 0, 0, 32'h0,   1, 32'h10, 0, 32'hA000_0003, 32'hC,  4, 0);
        vecs[13] = row(0, 0, 32'h0,         1, 1, 32'h100, 0, 32'h10, 1, 32'hA000_0004, 32'h10, 4, 0);
        vecs[14] = row(0, 1, 32'hA000_0005, 1, 1, 32'h200, 1, 32'h100,0, 32'hA000_0004, 32'h10, 5, 0);
        vecs[15] = row(0, 0, 32'h0,         0, 0, 32'h0,   0, 32'h100,1, 32'hA000_0005, 32'h100,5, 0);
        vecs[16] = row(0, 0, 32'h0,         1, 1, 32'h102, 0, 32'h100,1, 32'hA000_0005, 32'h100,5, 0);
`ifdef PC_MISALIGN_TRAP_EN
        vecs[17] = row(0, 0, 32'h0,         0, 0, 32'h0,   0, 32'h100,0, 32'hA000_0005, 32'h100,5, 1);
        vecs[18] = row(0, 1, 32'hA000_0006, 0, 0, 32'h0,   0, 32'h100,0, 32'hA000_0005, 32'h100,5, 1);
        vecs[19] = row(0, 0, 32'h0,         1, 0, 32'h0,   0, 32'h100,0, 32'hA000_0005, 32'h100,5, 1);
`else
        vecs[17] = row(0, 0, 32'h0,         0, 0, 32'h0,   1, 32'h100,0, 32'hA000_0005, 32'h100,6, 0);
        vecs[18] = row(0, 1, 32'hA000_0006, 0, 0, 32'h0,   1, 32'h100,0, 32'hA000_0005, 32'h100,6, 0);
        vecs[19] = row(0, 0, 32'h0,         0, 0, 32'h0,   0, 32'h100,1, 32'hA000_0006, 32'h100,6, 0);
`endif

        do_reset();
        for (int i = 0; i < 20; i++) begin
            apply(vecs[i].stall, vecs[i].ack, vecs[i].rdata, vecs[i].done, vecs[i].br,
                  vecs[i].tgt);
            chk($sformatf("vec%0d.req", i), {31'h0, bus.imem_req}, {31'h0, vecs[i].exp_req});
            chk($sformatf("vec%0d.addr", i), bus.imem_addr, vecs[i].exp_addr);
            chk($sformatf("vec%0d.valid", i), {31'h0, bus.instr_valid},
                {31'h0, vecs[i].exp_valid});
            chk($sformatf("vec%0d.instr", i), bus.instr, vecs[i].exp_instr);
            chk($sformatf("vec%0d.pc_out", i), bus.pc_out, vecs[i].exp_pc_out);
            chk($sformatf("vec%0d.retire", i), bus.retire_cnt, vecs[i].exp_retire);
            chk($sformatf("vec%0d.trap", i), {31'h0, bus.trap}, {31'h0, vecs[i].exp_trap});
        end

        // Asynchronous reset while an instruction is held for execute.
        do_reset();
        apply(0, 1, 32'hA000_0007, 0, 0, 32'h0);
        apply(0, 0, 32'h0, 1, 1, 32'h200);
        apply(0, 1, 32'hA000_0008, 0, 0, 32'h0);
        apply(0, 1, 32'h0, 0, 0, 32'h0);
        chk("rstmid.valid_before", {31'h0, bus.instr_valid}, 32'h1);
        chk("rstmid.pc_out_before", bus.pc_out, 32'h200);
        rst = 1'b1;
        #1;
        chk("rstmid.valid", {31'h0, bus.instr_valid}, 32'h0);
        chk("rstmid.addr", bus.imem_addr, 32'h0);
        chk("rstmid.instr", bus.instr, 32'h0);
        chk("rstmid.retire", bus.retire_cnt, 32'h0);
        chk("rstmid.req", {31'h0, bus.imem_req}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.imem_ack = 1'b0;
        #1;
        chk("rstack.valid", {31'h0, bus.instr_valid}, 32'h0);
        chk("rstack.instr", bus.instr, 32'h0);

        // PC wrap from the top of the address space.
        apply(0, 1, 32'hA000_0009, 0, 0, 32'h0);
        apply(0, 0, 32'h0, 1, 1, 32'hFFFF_FFFC);
        apply(0, 1, 32'hA000_000A, 0, 0, 32'h0);
        chk("wrap.addr_top", bus.imem_addr, 32'hFFFF_FFFC);
        apply(0, 0, 32'h0, 1, 0, 32'h0);
        chk("wrap.pc_out", bus.pc_out, 32'hFFFF_FFFC);
        apply(0, 0, 32'h0, 0, 0, 32'h0);
        chk("wrap.addr", bus.imem_addr, 32'h0);
        chk("wrap.retire", bus.retire_cnt, 32'h2);

        // Randomized traffic against the model, with occasional resets.
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            logic        r_rst, r_s, r_a, r_d, r_b;
            logic [31:0] r_rd, r_t;
            r_rst = ($urandom_range(0, 99) == 0);
            r_s   = ($urandom_range(0, 3) == 0);
            r_a   = $urandom_range(0, 1) == 1;
            r_d   = $urandom_range(0, 1) == 1;
            r_b   = $urandom_range(0, 1) == 1;
            r_rd  = $urandom;
            r_t   = $urandom;
            if ($urandom_range(0, 7) != 0) r_t = r_t & 32'hFFFF_FFFC;
            if ($urandom_range(0, 15) == 0) r_t = 32'hFFFF_FFFC;
            apply(r_s, r_a, r_rd, r_d, r_b, r_t);
            rst = r_rst;
            #1;
            if (r_rst) model_reset();
            check_model($sformatf("rnd%0d", n));
            if (!r_rst) model_edge(r_s, r_a, r_rd, r_d, r_b, r_t);
        end
        @(negedge clk);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 imem_req  output  1  instruction fetch request to instruction memory.
REQ-005 imem_addr  output  32  fetch address; equals current PC.
REQ-006 imem_ack  input  1  fetch complete; imem_rdata valid this cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 stall  input  1  hazard/hold request; suppresses fetch.
REQ-009 instr_valid  output  1  instr/pc_out hold a live instruction for execute.
REQ-010 instr  output  32  latched instruction word.
REQ-011 pc_out  output  32  PC of the latched instruction.
REQ-012 exec_done  input  1  execute finished the issued instruction.
REQ-013 take_branch  input  1  branch/jump decision for the issued instruction, sampled with exec_done.
REQ-014 branch_target  input  32  target address, sampled with exec_done.
REQ-015 retire_cnt  output  32  count of retired instructions.
REQ-016 trap  output  1  sticky misaligned-target trap flag.

Function
REQ-017 The FSM SHALL have three states: FETCH, WAIT_EXEC, TRAP; reset state is FETCH.
REQ-018 In FETCH, imem_req SHALL equal !stall and imem_addr SHALL equal PC, held stable until accepted.
REQ-019 In FETCH, imem_ack with imem_req high SHALL latch imem_rdata into instr and PC into pc_out, then move to WAIT_EXEC; imem_ack with imem_req low SHALL be ignored.
REQ-020 In WAIT_EXEC, instr_valid SHALL be 1 and imem_req 0; instr_valid SHALL be 0 in all other states.
REQ-021 In WAIT_EXEC, exec_done SHALL select next PC = take_branch ? branch_target : PC+4 (modulo 2^32, 32'hFFFF_FFFC+4 wraps to 0), load it into PC, increment retire_cnt (wrapping), and return to FETCH.
REQ-022 exec_done, take_branch and branch_target outside WAIT_EXEC SHALL be ignored.
REQ-023 Minimum instruction period SHALL be 2 cycles (ack in FETCH cycle n, exec_done in WAIT_EXEC cycle n+1, next FETCH at n+2).
REQ-024 stall SHALL not affect WAIT_EXEC.
REQ-025 In TRAP, imem_req and instr_valid SHALL be 0, trap SHALL be 1, PC and retire_cnt SHALL hold; TRAP is exited only by reset.

Reset
REQ-026 rst SHALL asynchronously force: state FETCH, PC=RESET_PC, instr=0, pc_out=0, retire_cnt=0, trap=0; thus imem_req=1 (if !stall), imem_addr=RESET_PC, instr_valid=0.
REQ-027 Reset mid-fetch or mid-execute SHALL abandon the transaction; an ack arriving during rst SHALL be dropped.

Configuration
REQ-028 Macro PC_MISALIGN_TRAP_EN: when defined, exec_done with take_branch=1 and branch_target[1:0]!=0 SHALL move to TRAP, set trap, not update PC, not increment retire_cnt.
REQ-029 When undefined, branch_target[1:0] SHALL be forced to 00 before loading PC, TRAP is unreachable, and trap SHALL be constant 0.

Structure
REQ-030 A shared package SHALL hold the state encoding (FETCH/WAIT_EXEC/TRAP), the PC increment constant 4 and the default reset vector.
REQ-031 The design SHALL be a single module; next-PC selection is inline, no sub-module.

Verification
REQ-032 Reset release, imem_ack same cycle, exec_done next cycle, take_branch=0 -> imem_addr sequence 0,4,8; retire_cnt=3 after three instructions.
REQ-033 Branch: issued PC=0x10, exec_done with take_branch=1, target=0x100 -> next imem_addr=0x100, retire_cnt increments by 1.
REQ-034 stall=1 for 3 cycles in FETCH with imem_ack pulsed -> imem_req=0, ack ignored, instr unchanged; fetch proceeds after stall drops.
REQ-035 Target 0x102 with take_branch=1 -> defined: trap=1, imem_req=0, PC holds, retire_cnt unchanged; undefined: next imem_addr=0x100.
REQ-036 rst pulsed in WAIT_EXEC with instr_valid=1 -> instr_valid=0, PC=RESET_PC immediately without clock edge; wrap check: PC=0xFFFF_FFFC, no branch -> next imem_addr=0.
